// File: rtl/cpu_irq_sched_if.sv
// cpu_irq_sched_if: CPU <-> interrupt scheduler signal bundle
interface cpu_irq_sched_if #(
    parameter int N_SRC  = 4,
    parameter int ID_W   = $clog2(N_SRC),
    parameter int ADDR_W = 10
);
    logic [N_SRC-1:0]  irq_in;
    logic              mask_we;
    logic [N_SRC-1:0]  mask_wdata;
    logic              int_ack;
    logic              reti;
    logic              int_req;
    logic [ADDR_W-1:0] int_vec;
    logic [ID_W-1:0]   int_id;
    logic              int_active;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  mask;

    modport master (
        output irq_in, mask_we, mask_wdata, int_ack, reti,
        input  int_req, int_vec, int_id, int_active, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, int_ack, reti,
        output int_req, int_vec, int_id, int_active, pending, mask
    );
endinterface

// File: rtl/cpu_irq_sched.sv
// cpu_irq_sched: edge-triggered, fixed-priority, non-nesting interrupt scheduler
module cpu_irq_sched #(
    parameter int                 N_SRC      = 4,
    parameter int                 ID_W       = $clog2(N_SRC),
    parameter int                 ADDR_W     = 10,
    parameter logic [ADDR_W-1:0]  VEC_BASE   = 10'h3F0,
    parameter int                 VEC_STRIDE = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    cpu_irq_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t           state_q;
    logic [N_SRC-1:0] irq_q, pend_q, pend_d, mask_q, mask_d, rise, clr, elig;
    logic [ID_W-1:0]  id_q, sel_id;
    logic             req_q, act_q;

    // Rising edges set pending; an ack clears the in-service bit unless it re-rises
    always_comb begin
        rise   = bus.irq_in & ~irq_q;
        clr    = (state_q == REQ && bus.int_ack) ? (N_SRC'(1) << id_q) : '0;
        pend_d = (pend_q & ~clr) | rise;
        mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
        elig   = pend_q & mask_q;
    end

    // Lowest-index eligible source wins
    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (elig[i]) sel_id = ID_W'(i);
    end

    // Edge-detect, pending and mask registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            irq_q  <= bus.irq_in;
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    // Request/service FSM with registered int_req, int_active and int_id
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            act_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (elig != '0) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    id_q    <= sel_id;
                end
                REQ: if (bus.int_ack) begin
                    state_q <= SERV;
                    req_q   <= 1'b0;
                    act_q   <= 1'b1;
                end else if (!mask_q[id_q]) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
                SERV: if (bus.reti) begin
                    state_q <= IDLE;
                    act_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    act_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req    = req_q;
    assign bus.int_active = act_q;
    assign bus.int_id     = id_q;
    assign bus.int_vec    = VEC_BASE + ADDR_W'(id_q) * ADDR_W'(VEC_STRIDE);
    assign bus.pending    = pend_q;
    assign bus.mask       = mask_q;
endmodule
